// File: rtl/sha256_xmss_pkg.sv
// Shared constants, FSM encoding and block-count helper for the XMSS SHA-256
// message controller.
package sha256_xmss_pkg;
  localparam int         WORD_W   = 256;
  localparam int         BLOCK_W  = 512;
  localparam logic [7:0] PAD_BYTE = 8'h80;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WAIT_DATA,
    ST_ISSUE,
    ST_WAIT_CORE,
    ST_FINISH
  } state_t;

  // Padded block count for an n-word (256-bit word) message.
  function automatic int block_count(input int n);
    return n / 2 + 1;
  endfunction
endpackage

// File: rtl/sha256_xmss_padder.sv
// Builds padded SHA-256 block k of an n-word message and reports how many
// leading message words must be valid before that block can be issued.
module sha256_xmss_padder
  import sha256_xmss_pkg::*;
#(
  parameter  int MAX_WORDS = 4,
  localparam int WW        = $clog2(MAX_WORDS + 1)
) (
  input  logic [MAX_WORDS*WORD_W-1:0] data_in,
  input  logic [WW-1:0]               n,
  input  logic [WW-1:0]               k,
  output logic [BLOCK_W-1:0]          block,
  output logic [WW-1:0]               need_words
);

  logic              last;
  logic [WW-1:0]     k_dbl;
  logic [WW-1:0]     lo_idx;
  logic [WW-1:0]     hi_idx;
  logic [WORD_W-1:0] w_lo;
  logic [WORD_W-1:0] w_hi;
  logic [63:0]       len_bits;

  assign last     = (k == (n >> 1));
  assign k_dbl    = k << 1;
  assign lo_idx   = last ? (n - WW'(1)) : k_dbl;
  assign hi_idx   = k_dbl + WW'(1);
  assign len_bits = 64'({n, 8'h00});

  // Word 0 sits in the most significant slice of data_in.
  always_comb begin
    w_lo = '0;
    w_hi = '0;
    for (int i = 0; i < MAX_WORDS; i++) begin
      if (WW'(i) == lo_idx) w_lo = data_in[(MAX_WORDS-i)*WORD_W-1 -: WORD_W];
      if (WW'(i) == hi_idx) w_hi = data_in[(MAX_WORDS-i)*WORD_W-1 -: WORD_W];
    end
  end

  always_comb begin
    block      = '0;
    need_words = '0;
    if (!last) begin
      block      = {w_lo, w_hi};
      need_words = k_dbl + WW'(2);
    end else if (n[0]) begin
      block      = {w_lo, PAD_BYTE, 184'd0, len_bits};
      need_words = n;
    end else begin
      block      = {PAD_BYTE, 440'd0, len_bits};
    end
  end

endmodule

// File: rtl/sha256_xmss_multiblock.sv
// Multi-block SHA-256 message controller: pads an n-word message and feeds the
// shared compression core one block at a time, with optional prefix reuse.
module sha256_xmss_multiblock
  import sha256_xmss_pkg::*;
#(
  parameter  int MAX_WORDS = 4,
  localparam int WW        = $clog2(MAX_WORDS + 1)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic                        init_iv,
  input  logic [WW-1:0]               msg_words,
  input  logic [WW-1:0]               words_avail,
  input  logic [MAX_WORDS*WORD_W-1:0] data_in,
  input  logic                        store_intermediate,
  input  logic                        continue_intermediate,
  output logic [WORD_W-1:0]           data_out,
  output logic                        data_out_valid,
  output logic                        done,
  output logic                        busy,
  output logic                        sha256_start,
  output logic                        sha256_init_message,
  output logic                        sha256_init_iv,
  output logic [BLOCK_W-1:0]          sha256_data_in,
  output logic                        sha256_load_state,
  output logic [WORD_W-1:0]           sha256_state_in,
  input  logic [WORD_W-1:0]           sha256_data_out,
  input  logic                        sha256_data_out_valid,
  input  logic                        sha256_done,
  input  logic                        sha256_busy
);

  // state        | meaning
  // ST_IDLE      | waiting for start
  // ST_LOAD      | pulse load_state with the stored prefix
  // ST_WAIT_DATA | waiting for the block's words and an idle core
  // ST_ISSUE     | pulse sha256_start
  // ST_WAIT_CORE | waiting for sha256_done
  // ST_FINISH    | pulse done
  state_t             state;
  state_t             state_nxt;
  logic [WW-1:0]      n_reg;
  logic [WW-1:0]      k_reg;
  logic [WW-1:0]      n_sat;
  logic [WW-1:0]      need_words;
  logic               store_req;
  logic               resume;
  logic               last_block;
  logic [WORD_W-1:0]  prefix_reg;
  logic               prefix_valid;
  logic [BLOCK_W-1:0] pad_block;
  logic               unused_core_valid;

  // Progress is tracked from sha256_done alone.
  assign unused_core_valid = sha256_data_out_valid;

  assign n_sat      = (msg_words > WW'(MAX_WORDS)) ? WW'(MAX_WORDS) : msg_words;
  assign resume     = continue_intermediate && prefix_valid && !init_iv && (int'(n_sat) >= 2);
  assign last_block = (int'(k_reg) == block_count(int'(n_reg)) - 1);
  assign sha256_state_in = prefix_reg;

  sha256_xmss_padder #(.MAX_WORDS(MAX_WORDS)) u_padder (
    .data_in    (data_in),
    .n          (n_reg),
    .k          (k_reg),
    .block      (pad_block),
    .need_words (need_words)
  );

  always_ff @(posedge clk) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt           = state;
    busy                = (state != ST_IDLE);
    done                = 1'b0;
    sha256_start        = 1'b0;
    sha256_init_message = 1'b0;
    sha256_init_iv      = 1'b0;
    sha256_load_state   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) state_nxt = resume ? ST_LOAD : ST_WAIT_DATA;
      end
      ST_LOAD: begin
        sha256_load_state = 1'b1;
        state_nxt         = ST_WAIT_DATA;
      end
      ST_WAIT_DATA: begin
        if ((words_avail >= need_words) && !sha256_busy) state_nxt = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (!sha256_busy) begin
          sha256_start        = 1'b1;
          sha256_init_message = 1'b1;
          sha256_init_iv      = (k_reg == '0);
          state_nxt           = ST_WAIT_CORE;
        end
      end
      ST_WAIT_CORE: begin
        if (sha256_done) state_nxt = last_block ? ST_FINISH : ST_WAIT_DATA;
      end
      ST_FINISH: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      n_reg          <= '0;
      k_reg          <= '0;
      store_req      <= 1'b0;
      prefix_reg     <= '0;
      prefix_valid   <= 1'b0;
      data_out       <= '0;
      data_out_valid <= 1'b0;
      sha256_data_in <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (init_iv) prefix_valid <= 1'b0;
          if (start) begin
            n_reg          <= n_sat;
            k_reg          <= resume ? WW'(1) : '0;
            store_req      <= store_intermediate && !resume && (int'(n_sat) >= 2);
            data_out_valid <= 1'b0;
          end
        end
        ST_WAIT_DATA: begin
          if (state_nxt == ST_ISSUE) sha256_data_in <= pad_block;
        end
        ST_WAIT_CORE: begin
          if (sha256_done) begin
            if (store_req && (k_reg == '0)) begin
              prefix_reg   <= sha256_data_out;
              prefix_valid <= 1'b1;
            end
            if (last_block) begin
              data_out       <= sha256_data_out;
              data_out_valid <= 1'b1;
            end else begin
              k_reg <= k_reg + WW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_xmss_multiblock.sv
// Directed bench for the multi-block SHA-256 controller, with a behavioural
// compression core and an independent SHA-256 reference.
module tb_sha256_xmss_multiblock;

  localparam int MAX_WORDS = 4;
  localparam int WW        = $clog2(MAX_WORDS + 1);
  localparam int DW        = MAX_WORDS * 256;
  localparam int CORE_LAT  = 6;

  localparam logic [255:0] IV =
    256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [31:0] K_TAB [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  logic           clk = 1'b0;
  logic           reset;
  logic           start;
  logic           init_iv;
  logic [WW-1:0]  msg_words;
  logic [WW-1:0]  words_avail;
  logic [DW-1:0]  data_in;
  logic           store_intermediate;
  logic           continue_intermediate;
  logic [255:0]   data_out;
  logic           data_out_valid;
  logic           done;
  logic           busy;
  logic           sha256_start;
  logic           sha256_init_message;
  logic           sha256_init_iv;
  logic [511:0]   sha256_data_in;
  logic           sha256_load_state;
  logic [255:0]   sha256_state_in;
  logic [255:0]   core_h;
  logic [255:0]   core_pending;
  logic           core_valid;
  logic           core_done;
  logic           core_busy;
  int             core_cnt;

  int n_checks = 0;
  int n_errors = 0;
  int n_starts = 0;
  int n_loads = 0;
  int n_dones = 0;
  int n_busy_issue = 0;

  always #5 clk = ~clk;

  sha256_xmss_multiblock #(.MAX_WORDS(MAX_WORDS)) dut (
    .clk                   (clk),
    .reset                 (reset),
    .start                 (start),
    .init_iv               (init_iv),
    .msg_words             (msg_words),
    .words_avail           (words_avail),
    .data_in               (data_in),
    .store_intermediate    (store_intermediate),
    .continue_intermediate (continue_intermediate),
    .data_out              (data_out),
    .data_out_valid        (data_out_valid),
    .done                  (done),
    .busy                  (busy),
    .sha256_start          (sha256_start),
    .sha256_init_message   (sha256_init_message),
    .sha256_init_iv        (sha256_init_iv),
    .sha256_data_in        (sha256_data_in),
    .sha256_load_state     (sha256_load_state),
    .sha256_state_in       (sha256_state_in),
    .sha256_data_out       (core_h),
    .sha256_data_out_valid (core_valid),
    .sha256_done           (core_done),
    .sha256_busy           (core_busy)
  );

  function automatic logic [31:0] ror32(input logic [31:0] x, input int s);
    return (x >> s) | (x << (32 - s));
  endfunction

  function automatic logic [255:0] compress(input logic [255:0] h_in, input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, g, h, s0, s1, t1, t2;
    for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
    for (int i = 16; i < 64; i++) begin
      s0 = ror32(w[i-15], 7) ^ ror32(w[i-15], 18) ^ (w[i-15] >> 3);
      s1 = ror32(w[i-2], 17) ^ ror32(w[i-2], 19) ^ (w[i-2] >> 10);
      w[i] = w[i-16] + s0 + w[i-7] + s1;
    end
    {a, b, c, d, e, f, g, h} = h_in;
    for (int i = 0; i < 64; i++) begin
      s1 = ror32(e, 6) ^ ror32(e, 11) ^ ror32(e, 25);
      t1 = h + s1 + ((e & f) ^ (~e & g)) + K_TAB[i] + w[i];
      s0 = ror32(a, 2) ^ ror32(a, 13) ^ ror32(a, 22);
      t2 = s0 + ((a & b) ^ (a & c) ^ (b & c));
      h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    return {a + h_in[255:224], b + h_in[223:192], c + h_in[191:160], d + h_in[159:128],
            e + h_in[127:96],  f + h_in[95:64],   g + h_in[63:32],   h + h_in[31:0]};
  endfunction

  function automatic logic [255:0] word_of(input logic [DW-1:0] d, input int i);
    return d[DW-1-256*i -: 256];
  endfunction

  function automatic logic [255:0] golden(input logic [DW-1:0] d, input int n);
    logic [255:0] h;
    logic [511:0] blk;
    logic [63:0]  len;
    h   = IV;
    len = 64'(n) * 64'd256;
    for (int k = 0; k < n / 2; k++) h = compress(h, {word_of(d, 2*k), word_of(d, 2*k+1)});
    if (n % 2 == 1) blk = {word_of(d, n-1), 8'h80, 184'd0, len};
    else            blk = {8'h80, 440'd0, len};
    return compress(h, blk);
  endfunction

  // Behavioural compression core: fixed latency, done and busy-drop together.
  always @(posedge clk) begin
    if (!reset) begin
      core_h       <= '0;
      core_pending <= '0;
      core_valid   <= 1'b0;
      core_done    <= 1'b0;
      core_busy    <= 1'b0;
      core_cnt     <= 0;
    end else begin
      core_done <= 1'b0;
      if (sha256_load_state) core_h <= sha256_state_in;
      if (sha256_start) begin
        core_pending <= compress(sha256_init_iv ? IV : core_h, sha256_data_in);
        core_busy    <= 1'b1;
        core_valid   <= 1'b0;
        core_cnt     <= CORE_LAT;
      end else if (core_busy) begin
        if (core_cnt == 1) begin
          core_busy  <= 1'b0;
          core_done  <= 1'b1;
          core_valid <= 1'b1;
          core_h     <= core_pending;
        end
        core_cnt <= core_cnt - 1;
      end
    end
  end

  always @(negedge clk) begin
    if (sha256_start) n_starts++;
    if (sha256_load_state) n_loads++;
    if (done) n_dones++;
    if (sha256_start && core_busy) n_busy_issue++;
  end

  task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_start(input logic [WW-1:0] n, input logic st, input logic ct);
    @(negedge clk);
    msg_words             = n;
    store_intermediate    = st;
    continue_intermediate = ct;
    start                 = 1'b1;
    @(negedge clk);
    start                 = 1'b0;
    store_intermediate    = 1'b0;
    continue_intermediate = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int cyc;
    cyc = 0;
    while (!done && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    check_eq({tag, "_done_seen"}, 512'(done), 512'd1);
    check_eq({tag, "_valid"}, 512'(data_out_valid), 512'd1);
    @(negedge clk);
    check_eq({tag, "_done_single"}, 512'(done), 512'd0);
    #1;
  endtask

  initial begin
    logic [DW-1:0] rnd_a;
    logic [DW-1:0] rnd_b;
    logic [255:0]  g4;
    int s0, l0, d0, cyc;

    reset = 1'b0; start = 1'b0; init_iv = 1'b0; msg_words = '0; words_avail = '0;
    data_in = '0; store_intermediate = 1'b0; continue_intermediate = 1'b0;
    for (int i = 0; i < DW / 32; i++) rnd_a[i*32 +: 32] = $urandom;
    for (int i = 0; i < DW / 32; i++) rnd_b[i*32 +: 32] = $urandom;
    repeat (3) @(negedge clk);
    check_eq("rst_data_out", 512'(data_out), 512'd0);
    check_eq("rst_valid", 512'(data_out_valid), 512'd0);
    check_eq("rst_busy", 512'(busy), 512'd0);
    check_eq("rst_blk", sha256_data_in, 512'd0);
    reset = 1'b1;

    // n=0: a single padding block gives SHA256("")
    s0 = n_starts; d0 = n_dones;
    do_start(0, 1'b0, 1'b0);
    wait_done("n0");
    check_eq("n0_digest", 512'(data_out),
             512'(256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855));
    check_eq("n0_starts", 512'(n_starts - s0), 512'd1);
    check_eq("n0_dones", 512'(n_dones - d0), 512'd1);
    check_eq("n0_busy_after", 512'(busy), 512'd0);

    // n=1, zero word: also checks issue latency and the padded block itself
    words_avail = WW'(1);
    s0 = n_starts;
    do_start(1, 1'b0, 1'b0);
    check_eq("n1_busy", 512'(busy), 512'd1);
    check_eq("n1_valid_cleared", 512'(data_out_valid), 512'd0);
    check_eq("n1_no_early_issue", 512'(sha256_start), 512'd0);
    @(negedge clk);
    check_eq("n1_issue", 512'(sha256_start), 512'd1);
    check_eq("n1_init_iv", 512'(sha256_init_iv), 512'd1);
    check_eq("n1_block", sha256_data_in, {256'd0, 8'h80, 184'd0, 64'd256});
    wait_done("n1");
    check_eq("n1_digest", 512'(data_out),
             512'(256'h66687aadf862bd776c8fc18b8e9f8e20089714856ee233b3902a591d0d5f2925));
    check_eq("n1_starts", 512'(n_starts - s0), 512'd1);

    // n=2: block 0 must wait for both words
    words_avail = '0;
    s0 = n_starts;
    do_start(2, 1'b0, 1'b0);
    repeat (20) @(negedge clk);
    check_eq("n2_stall_starts", 512'(n_starts - s0), 512'd0);
    check_eq("n2_stall_busy", 512'(busy), 512'd1);
    words_avail = WW'(2);
    wait_done("n2");
    check_eq("n2_digest", 512'(data_out),
             512'(256'hf5a5fd42d16a20302798ef6ed309979b43003d2320d9f0e8ea9831a92759fb4b));
    check_eq("n2_starts", 512'(n_starts - s0), 512'd2);

    // n=4 random with store, then resume from the stored prefix
    words_avail = WW'(4);
    data_in = rnd_a;
    g4 = golden(rnd_a, 4);
    s0 = n_starts; l0 = n_loads;
    do_start(4, 1'b1, 1'b0);
    wait_done("store");
    check_eq("store_digest", 512'(data_out), 512'(g4));
    check_eq("store_starts", 512'(n_starts - s0), 512'd3);
    check_eq("store_prefix", 512'(sha256_state_in),
             512'(compress(IV, {word_of(rnd_a, 0), word_of(rnd_a, 1)})));
    s0 = n_starts;
    do_start(4, 1'b0, 1'b1);
    check_eq("resume_load_pulse", 512'(sha256_load_state), 512'd1);
    wait_done("resume");
    check_eq("resume_digest", 512'(data_out), 512'(g4));
    check_eq("resume_starts", 512'(n_starts - s0), 512'd2);
    check_eq("resume_loads", 512'(n_loads - l0), 512'd1);

    // init_iv invalidates the prefix, so continue falls back to the IV
    @(negedge clk); init_iv = 1'b1;
    @(negedge clk); init_iv = 1'b0;
    data_in = rnd_b;
    s0 = n_starts; l0 = n_loads;
    do_start(3, 1'b0, 1'b1);
    wait_done("fallback");
    check_eq("fallback_digest", 512'(data_out), 512'(golden(rnd_b, 3)));
    check_eq("fallback_starts", 512'(n_starts - s0), 512'd2);
    check_eq("fallback_loads", 512'(n_loads - l0), 512'd0);

    // msg_words above MAX_WORDS saturates
    s0 = n_starts;
    do_start(7, 1'b0, 1'b0);
    wait_done("sat");
    check_eq("sat_digest", 512'(data_out), 512'(golden(rnd_b, 4)));
    check_eq("sat_starts", 512'(n_starts - s0), 512'd3);

    // Reset while the core is working aborts the operation
    do_start(4, 1'b0, 1'b0);
    cyc = 0;
    while (!sha256_start && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check_eq("abort_issue_seen", 512'(sha256_start), 512'd1);
    repeat (2) @(negedge clk);
    d0 = n_dones;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("abort_data_out", 512'(data_out), 512'd0);
    check_eq("abort_valid", 512'(data_out_valid), 512'd0);
    check_eq("abort_busy", 512'(busy), 512'd0);
    check_eq("abort_blk", sha256_data_in, 512'd0);
    check_eq("abort_state_in", 512'(sha256_state_in), 512'd0);
    reset = 1'b1;
    repeat (CORE_LAT + 4) @(negedge clk);
    check_eq("abort_no_done", 512'(n_dones - d0), 512'd0);

    // Fresh n=1 run with a second start while busy
    data_in = rnd_a;
    s0 = n_starts; d0 = n_dones;
    do_start(1, 1'b0, 1'b0);
    msg_words = WW'(4);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("post_rst");
    check_eq("post_rst_digest", 512'(data_out), 512'(golden(rnd_a, 1)));
    check_eq("post_rst_starts", 512'(n_starts - s0), 512'd1);
    check_eq("post_rst_dones", 512'(n_dones - d0), 512'd1);
    check_eq("issue_while_core_busy", 512'(n_busy_issue), 512'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
